// File: rtl/conv_run_scheduler_pkg.sv
// rtl/conv_run_scheduler_pkg.sv - shared states, select indices and default budgets for the run scheduler
package conv_run_scheduler_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_RUN_PE  = 3'd3;
    localparam logic [2:0] ST_RUN_3B3 = 3'd4;
    localparam logic [2:0] ST_RUN_2B2 = 3'd5;
    localparam logic [2:0] ST_SHOW    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_CLEAR   = ST_CLEAR,
        S_LOAD    = ST_LOAD,
        S_RUN_PE  = ST_RUN_PE,
        S_RUN_3B3 = ST_RUN_3B3,
        S_RUN_2B2 = ST_RUN_2B2,
        S_SHOW    = ST_SHOW
    } state_t;

    localparam int SEL_PE  = 0;
    localparam int SEL_3B3 = 1;
    localparam int SEL_2B2 = 2;

    localparam int DEF_MEM_CYC = 4;
    localparam int DEF_PE_CYC  = 40;
    localparam int DEF_S3_CYC  = 12;
    localparam int DEF_S2_CYC  = 16;

    // First selected engine whose select index is at or after 'from'; SHOW when none remain.
    function automatic state_t first_engine(input logic [2:0] sel, input int from);
        if (from <= SEL_PE  && sel[SEL_PE])  return S_RUN_PE;
        if (from <= SEL_3B3 && sel[SEL_3B3]) return S_RUN_3B3;
        if (from <= SEL_2B2 && sel[SEL_2B2]) return S_RUN_2B2;
        return S_SHOW;
    endfunction

    function automatic logic is_timed(input state_t s);
        return s inside {S_LOAD, S_RUN_PE, S_RUN_3B3, S_RUN_2B2};
    endfunction

endpackage

// File: rtl/conv_run_scheduler_if.sv
// rtl/conv_run_scheduler_if.sv - control handshake and datapath release lines of the run scheduler
interface conv_run_scheduler_if #(
    parameter int ELAP_W = 16
);
    logic              start;
    logic [2:0]        eng_sel;
    logic              busy;
    logic              done;
    logic              rst_mem;
    logic              rst_pe;
    logic              rst_3b3;
    logic              rst_2b2;
    logic              rst_disp;
    logic [ELAP_W-1:0] elapsed;

    modport master (
        output start, eng_sel,
        input  busy, done, rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp, elapsed
    );

    modport slave (
        input  start, eng_sel,
        output busy, done, rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp, elapsed
    );
endinterface

// File: rtl/conv_run_scheduler_slot_timer.sv
// rtl/conv_run_scheduler_slot_timer.sv - loadable down-counter with zero flag shared by all slots
module conv_run_scheduler_slot_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
endmodule

// File: rtl/conv_run_scheduler.sv
// rtl/conv_run_scheduler.sv - sequences memory and engine reset release for one convolution run
module conv_run_scheduler
    import conv_run_scheduler_pkg::*;
#(
    parameter int MEM_CYC = DEF_MEM_CYC,
    parameter int PE_CYC  = DEF_PE_CYC,
    parameter int S3_CYC  = DEF_S3_CYC,
    parameter int S2_CYC  = DEF_S2_CYC,
    parameter int CNT_W   = 8,
    parameter int ELAP_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    conv_run_scheduler_if.slave bus
);
    state_t            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic              rst_mem_q, rst_mem_d;
    logic              rst_pe_q, rst_pe_d;
    logic              rst_3b3_q, rst_3b3_d;
    logic              rst_2b2_q, rst_2b2_d;
    logic              rst_disp_q, rst_disp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ELAP_W-1:0] elapsed_q, elapsed_d;
    logic              tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0]  tmr_val;
    logic              run_live;

    conv_run_scheduler_slot_timer #(.CNT_W(CNT_W)) u_slot_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE, S_SHOW: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    sel_d   = bus.eng_sel;
                end
            end
            S_CLEAR:   state_d = S_LOAD;
            S_LOAD:    if (tmr_zero) state_d = first_engine(sel_q, SEL_PE);
            S_RUN_PE:  if (tmr_zero) state_d = first_engine(sel_q, SEL_3B3);
            S_RUN_3B3: if (tmr_zero) state_d = first_engine(sel_q, SEL_2B2);
            S_RUN_2B2: if (tmr_zero) state_d = S_SHOW;
            default:   state_d = S_IDLE;
        endcase

        // The slot count is loaded on entry so a budget of B yields exactly B cycles.
        tmr_load = (state_d != state_q) && is_timed(state_d);
        tmr_en   = is_timed(state_q);
        case (state_d)
            S_LOAD:    tmr_val = CNT_W'(MEM_CYC - 1);
            S_RUN_PE:  tmr_val = CNT_W'(PE_CYC - 1);
            S_RUN_3B3: tmr_val = CNT_W'(S3_CYC - 1);
            S_RUN_2B2: tmr_val = CNT_W'(S2_CYC - 1);
            default:   tmr_val = '0;
        endcase

        // Release lines stick for the rest of the run, including SHOW, and drop in CLEAR/IDLE.
        run_live   = state_d inside {S_LOAD, S_RUN_PE, S_RUN_3B3, S_RUN_2B2, S_SHOW};
        rst_mem_d  = run_live && (rst_mem_q || state_d == S_LOAD);
        rst_pe_d   = run_live && (rst_pe_q  || state_d == S_RUN_PE);
        rst_3b3_d  = run_live && (rst_3b3_q || state_d == S_RUN_3B3);
        rst_2b2_d  = run_live && (rst_2b2_q || state_d == S_RUN_2B2);
        rst_disp_d = (state_d == S_SHOW);
        busy_d     = (state_d == S_CLEAR) || is_timed(state_d);
        done_d     = (state_d == S_SHOW) && (state_q != S_SHOW);

        elapsed_d = elapsed_q;
        if (state_d == S_CLEAR) begin
            elapsed_d = '0;
        end else if (is_timed(state_q) && elapsed_q != '1) begin
            elapsed_d = elapsed_q + ELAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            rst_mem_q  <= 1'b0;
            rst_pe_q   <= 1'b0;
            rst_3b3_q  <= 1'b0;
            rst_2b2_q  <= 1'b0;
            rst_disp_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            elapsed_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rst_mem_q  <= rst_mem_d;
            rst_pe_q   <= rst_pe_d;
            rst_3b3_q  <= rst_3b3_d;
            rst_2b2_q  <= rst_2b2_d;
            rst_disp_q <= rst_disp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            elapsed_q  <= elapsed_d;
        end
    end

    assign bus.rst_mem  = rst_mem_q;
    assign bus.rst_pe   = rst_pe_q;
    assign bus.rst_3b3  = rst_3b3_q;
    assign bus.rst_2b2  = rst_2b2_q;
    assign bus.rst_disp = rst_disp_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.elapsed  = elapsed_q;
endmodule

// File: tb/tb_conv_run_scheduler.sv
// tb/tb_conv_run_scheduler.sv - directed self-checking bench for conv_run_scheduler
module tb_conv_run_scheduler;
    logic clk;
    logic rst;

    conv_run_scheduler_if #(.ELAP_W(16)) bus ();

    conv_run_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          t_mem, t_pe, t_3b3, t_2b2, t_disp, t_done, done_cnt, busy_err;
    logic [15:0] el_done;
    logic        disp_done;
    logic [4:0]  clr_rst;
    logic [15:0] clr_el;

    // Cycle k is sampled on the falling edge after the k-th rising edge following the start cycle.
    task automatic trace_run(input logic [2:0] sel, input int inj_cyc, input logic [2:0] inj_sel,
                             input int max_cyc);
        t_mem = -1; t_pe = -1; t_3b3 = -1; t_2b2 = -1; t_disp = -1; t_done = -1;
        done_cnt = 0; busy_err = 0; el_done = '0; disp_done = 1'b0; clr_rst = '1; clr_el = '1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.eng_sel = sel;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (k == 1) begin
                clr_rst = {bus.rst_mem, bus.rst_pe, bus.rst_3b3, bus.rst_2b2, bus.rst_disp};
                clr_el  = bus.elapsed;
            end
            if (bus.rst_mem  && t_mem  < 0) t_mem  = k;
            if (bus.rst_pe   && t_pe   < 0) t_pe   = k;
            if (bus.rst_3b3  && t_3b3  < 0) t_3b3  = k;
            if (bus.rst_2b2  && t_2b2  < 0) t_2b2  = k;
            if (bus.rst_disp && t_disp < 0) t_disp = k;
            if (bus.done) begin
                done_cnt++;
                if (t_done < 0) begin
                    t_done = k; el_done = bus.elapsed; disp_done = bus.rst_disp;
                end
            end
            if (t_done < 0 && bus.busy !== 1'b1) busy_err++;
            if (t_done == k && bus.busy !== 1'b0) busy_err++;
            bus.start = (k == inj_cyc);
            if (k == inj_cyc) bus.eng_sel = inj_sel;
            if (t_done >= 0 && k >= t_done + 2) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b0; bus.start = 1'b0; bus.eng_sel = 3'b000;
        repeat (3) @(negedge clk);
        n_checks++; if ({bus.rst_mem, bus.rst_pe, bus.rst_3b3, bus.rst_2b2, bus.rst_disp, bus.busy, bus.done} !== 7'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want 0000000", {bus.rst_mem, bus.rst_pe, bus.rst_3b3, bus.rst_2b2, bus.rst_disp, bus.busy, bus.done}); end
        n_checks++; if (bus.elapsed !== 16'd0) begin n_fail++; $display("FAIL reset_elapsed: got %0d want 0", bus.elapsed); end
        rst = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({bus.rst_mem, bus.rst_pe, bus.rst_3b3, bus.rst_2b2, bus.rst_disp, bus.busy, bus.done} !== 7'b0 || bus.elapsed !== 16'd0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
        rst = 1'b0; bus.start = 1'b1; bus.eng_sel = 3'b111;
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_beats_start: busy got %b want 0", bus.busy); end
        @(negedge clk);
        n_checks++; if ({bus.busy, bus.rst_mem} !== 2'b00) begin n_fail++; $display("FAIL reset_beats_start_late: busy,rst_mem got %b want 00", {bus.busy, bus.rst_mem}); end
    endtask

    task automatic test_all_engines();
        trace_run(3'b111, 0, 3'b000, 100);
        n_checks++; if (t_mem  !== 2)  begin n_fail++; $display("FAIL all_mem_rise: got %0d want 2", t_mem); end
        n_checks++; if (t_pe   !== 6)  begin n_fail++; $display("FAIL all_pe_rise: got %0d want 6", t_pe); end
        n_checks++; if (t_3b3  !== 46) begin n_fail++; $display("FAIL all_3b3_rise: got %0d want 46", t_3b3); end
        n_checks++; if (t_2b2  !== 58) begin n_fail++; $display("FAIL all_2b2_rise: got %0d want 58", t_2b2); end
        n_checks++; if (t_done !== 74) begin n_fail++; $display("FAIL all_done_cycle: got %0d want 74", t_done); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL all_done_width: got %0d pulses want 1", done_cnt); end
        n_checks++; if (el_done !== 16'd72) begin n_fail++; $display("FAIL all_elapsed: got %0d want 72", el_done); end
        n_checks++; if (busy_err !== 0) begin n_fail++; $display("FAIL all_busy: got %0d bad cycles want 0", busy_err); end
        n_checks++; if ({bus.rst_mem, bus.rst_pe, bus.rst_3b3, bus.rst_2b2, bus.rst_disp} !== 5'b11111) begin n_fail++; $display("FAIL all_show_hold: got %b want 11111", {bus.rst_mem, bus.rst_pe, bus.rst_3b3, bus.rst_2b2, bus.rst_disp}); end
    endtask

    task automatic test_single_3b3();
        trace_run(3'b010, 0, 3'b000, 40);
        n_checks++; if (clr_rst !== 5'b00000) begin n_fail++; $display("FAIL s3_clear_lines: got %b want 00000", clr_rst); end
        n_checks++; if (clr_el !== 16'd0) begin n_fail++; $display("FAIL s3_clear_elapsed: got %0d want 0", clr_el); end
        n_checks++; if (t_mem !== 2) begin n_fail++; $display("FAIL s3_mem_rise: got %0d want 2", t_mem); end
        n_checks++; if (t_3b3 !== 6) begin n_fail++; $display("FAIL s3_3b3_rise: got %0d want 6", t_3b3); end
        n_checks++; if ({t_pe, t_2b2} !== {-32'sd1, -32'sd1}) begin n_fail++; $display("FAIL s3_others_held: pe %0d 2b2 %0d want -1 -1", t_pe, t_2b2); end
        n_checks++; if (t_done !== 18) begin n_fail++; $display("FAIL s3_done_cycle: got %0d want 18", t_done); end
        n_checks++; if (el_done !== 16'd16) begin n_fail++; $display("FAIL s3_elapsed: got %0d want 16", el_done); end
    endtask

    task automatic test_no_engine();
        trace_run(3'b000, 0, 3'b000, 20);
        n_checks++; if (t_done !== 6) begin n_fail++; $display("FAIL none_done_cycle: got %0d want 6", t_done); end
        n_checks++; if (el_done !== 16'd4) begin n_fail++; $display("FAIL none_elapsed: got %0d want 4", el_done); end
        n_checks++; if (disp_done !== 1'b1) begin n_fail++; $display("FAIL none_disp: got %b want 1", disp_done); end
        n_checks++; if ({t_pe, t_3b3, t_2b2} !== {-32'sd1, -32'sd1, -32'sd1}) begin n_fail++; $display("FAIL none_engines_held: %0d %0d %0d want -1", t_pe, t_3b3, t_2b2); end
    endtask

    task automatic test_ignore_and_restart();
        trace_run(3'b111, 50, 3'b001, 100);
        n_checks++; if (t_done !== 74) begin n_fail++; $display("FAIL midrun_done_cycle: got %0d want 74", t_done); end
        n_checks++; if (t_2b2 !== 58) begin n_fail++; $display("FAIL midrun_2b2_rise: got %0d want 58", t_2b2); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL midrun_done_width: got %0d want 1", done_cnt); end
        trace_run(3'b001, 0, 3'b000, 60);
        n_checks++; if (clr_rst !== 5'b00000) begin n_fail++; $display("FAIL restart_clear_lines: got %b want 00000", clr_rst); end
        n_checks++; if (clr_el !== 16'd0) begin n_fail++; $display("FAIL restart_clear_elapsed: got %0d want 0", clr_el); end
        n_checks++; if (t_pe !== 6) begin n_fail++; $display("FAIL restart_pe_rise: got %0d want 6", t_pe); end
        n_checks++; if (t_3b3 !== -1) begin n_fail++; $display("FAIL restart_3b3_held: got %0d want -1", t_3b3); end
        n_checks++; if (t_done !== 46) begin n_fail++; $display("FAIL restart_done_cycle: got %0d want 46", t_done); end
        n_checks++; if (el_done !== 16'd44) begin n_fail++; $display("FAIL restart_elapsed: got %0d want 44", el_done); end
    endtask

    task automatic test_reset_midrun();
        int bad;
        @(negedge clk);
        bus.start = 1'b1; bus.eng_sel = 3'b001;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        n_checks++; if (bus.rst_pe !== 1'b1) begin n_fail++; $display("FAIL abort_in_pe: rst_pe got %b want 1", bus.rst_pe); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++; if ({bus.rst_mem, bus.rst_pe, bus.rst_3b3, bus.rst_2b2, bus.rst_disp, bus.busy, bus.done} !== 7'b0) begin n_fail++; $display("FAIL abort_outputs: got %b want 0000000", {bus.rst_mem, bus.rst_pe, bus.rst_3b3, bus.rst_2b2, bus.rst_disp, bus.busy, bus.done}); end
        n_checks++; if (bus.elapsed !== 16'd0) begin n_fail++; $display("FAIL abort_elapsed: got %0d want 0", bus.elapsed); end
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if ({bus.rst_mem, bus.rst_pe, bus.rst_3b3, bus.rst_2b2, bus.rst_disp, bus.busy, bus.done} !== 7'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_stays_idle: got %0d active cycles want 0", bad); end
        trace_run(3'b001, 0, 3'b000, 60);
        n_checks++; if (t_pe !== 6) begin n_fail++; $display("FAIL after_abort_pe_rise: got %0d want 6", t_pe); end
        n_checks++; if (t_done !== 46) begin n_fail++; $display("FAIL after_abort_done_cycle: got %0d want 46", t_done); end
        n_checks++; if (el_done !== 16'd44) begin n_fail++; $display("FAIL after_abort_elapsed: got %0d want 44", el_done); end
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0;
        bus.eng_sel = 3'b000;
        test_reset();
        test_all_engines();
        test_single_3b3();
        test_no_engine();
        test_ignore_and_restart();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_run_scheduler.md
Name: conv_run_scheduler

Overview:
- Sequences one convolution run across the shared datapath: operand memory, 1x1 PE, 3x3 systolic array, 2x2 systolic array and 7-segment display.
- Drives the per-block active-low reset/enable lines so engines start one after another with fixed cycle budgets.
- Adds a start/busy/done handshake, per-run engine selection and an elapsed-cycle counter.
- Sits between top-level control inputs and the datapath in place of free-running reset release.

Parameters:
- MEM_CYC, 4: cycles memory is released before any engine starts.
- PE_CYC, 40: run budget, 1x1 PE slot.
- S3_CYC, 12: run budget, 3x3 systolic slot.
- S2_CYC, 16: run budget, 2x2 systolic slot.
- CNT_W, 8: width of slot counter; every budget must be ≤ 2^CNT_W-1 and ≥ 1.
- ELAP_W, 16: width of elapsed-cycle counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  level; sampled each cycle; a run begins on a cycle with start=1 in IDLE or SHOW.
- eng_sel  in  3  bit0 PE, bit1 3x3, bit2 2x2; captured at accepted start.
- busy  out  1  high from the cycle after an accepted start until entry to SHOW.
- done  out  1  one-cycle pulse on the cycle SHOW is entered.
- rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp  out  1 each  active-low; 0 holds the block in reset, 1 releases it.
- elapsed  out  ELAP_W  cycles spent in LOAD+engine states of the last/current run; saturates at all-ones.

Behaviour:
- Reset (rst=0 at edge): state=IDLE; all rst_* = 0; busy=0; done=0; elapsed=0; sel_q=0; slot counter=0.
- States: IDLE, CLEAR, LOAD, RUN_PE, RUN_3B3, RUN_2B2, SHOW.
- IDLE: all rst_* = 0. start=1 → CLEAR; sel_q<=eng_sel.
- CLEAR (exactly 1 cycle):
  - All rst_* = 0, elapsed<=0, busy=1 → LOAD.
  - Guarantees every engine sees a reset before a new run, including a restart from SHOW.
- LOAD: rst_mem=1; stay MEM_CYC cycles, then go to the first selected engine state in order PE, 3B3, 2B2; if sel_q=0 → SHOW.
- RUN_x: the engine's rst_x=1 for S cycles, where S is its budget. Then go to the next selected engine; if none remain → SHOW.
- Released lines are sticky within a run: once a rst_x goes to 1 it stays 1 until CLEAR/IDLE/reset, so finished engines hold their outputs.
- Slot counter: loads budget-1 on state entry and decrements; state exits on the cycle counter==0. A budget of B gives exactly B cycles in the state.
- SHOW:
  - rst_disp=1, busy=0, done=1 on the entry cycle only.
  - Remains until start=1 → CLEAR with a new sel_q.
  - Memory and engine enables keep their run values while in SHOW.
- elapsed increments by 1 each cycle in LOAD or any RUN_x; it holds in SHOW/IDLE and saturates at all-ones.
- start in CLEAR/LOAD/RUN_x is ignored, with no queuing.
- eng_sel changes mid-run have no effect.
- rst=0 mid-run: next cycle is IDLE with all outputs at reset values; the run is abandoned and no done pulse is issued.
- Simultaneous rst=0 and start=1: reset wins.
- Minimum latency, accepted start to done: 1 (CLEAR) + MEM_CYC + sum of selected budgets + 1 cycle.

Decomposition:
- Shared package:
  - state encoding localparams (3-bit) for the seven states;
  - engine-select bit indices (SEL_PE=0, SEL_3B3=1, SEL_2B2=2);
  - default budget constants, so the top and benches agree.
- One sub-module is natural: slot_timer. It is a loadable down-counter with a zero flag, CNT_W wide, with load/enable inputs, and one instance is shared by all slots.
- FSM, sticky-release flags and the elapsed counter live in conv_run_scheduler.

Test Plan:
- Reset then idle 10 cycles with start=0 → all rst_* = 0, busy=0, done never pulses, elapsed=0.
- start=1 one cycle, eng_sel=3'b111, defaults:
  - rst_mem rises 2 cycles later; rst_pe rises 4 cycles after that; rst_3b3 40 cycles later; rst_2b2 12 cycles later;
  - done pulses 16 cycles later, exactly 1 cycle wide;
  - elapsed=72 and busy=0 in SHOW.
- eng_sel=3'b010: only rst_mem and rst_3b3 rise; rst_pe and rst_2b2 stay 0; done 1+4+12+1 = 18 cycles after start; elapsed=16.
- eng_sel=3'b000: LOAD 4 cycles, then SHOW; done 6 cycles after start; elapsed=4; rst_disp=1.
- start pulsed in RUN_3B3, and eng_sel flipped to 3'b001 mid-run → no change in sequence or timing; then in SHOW, start=1 → one CLEAR cycle with all rst_*=0, elapsed=0, new run with PE only.
- rst=0 asserted during RUN_PE cycle 20 → next cycle all rst_*=0, busy=0, state IDLE, no done pulse; start after release runs normally from CLEAR.
